// File: rtl/link_buffer.sv
// link_buffer: flit FIFO between two router ports with credit-style flow control.
// Parameters:
//   FLIT_WIDTH  flit width in bits
//   DEPTH       capacity in flits (power of two, >= 2)
// Ports:
//   clock, reset       rising-edge clock, async active-low reset
//   rx, data_i         upstream flit valid and flit data
//   credit_o           buffer can accept a flit this cycle
//   tx, data_o         head flit valid and head flit data
//   credit_i           downstream accepts the head flit this cycle
//   count_o            current occupancy
// Optional macro LINK_STATS_EN adds the following read-side packet statistics:
//   flit_cnt_o         flits delivered downstream
//   pkt_cnt_o          packets delivered downstream
module link_buffer #(
    parameter int FLIT_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    rx,
    input  logic [FLIT_WIDTH-1:0]   data_i,
    output logic                    credit_o,
    output logic                    tx,
    output logic [FLIT_WIDTH-1:0]   data_o,
    input  logic                    credit_i,
    output logic [$clog2(DEPTH):0]  count_o
`ifdef LINK_STATS_EN
    ,
    output logic [31:0]             flit_cnt_o,
    output logic [31:0]             pkt_cnt_o
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

    logic [FLIT_WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]         wptr;
    logic [AW-1:0]         rptr;
    logic [AW:0]           count;
    logic                  wr;
    logic                  rd;

    // Flow control is decoded from the registered count only.
    assign credit_o = (count < FULL);
    assign tx       = (count != '0);
    assign count_o  = count;
    assign wr       = rx & credit_o;
    assign rd       = tx & credit_i;

    // Storage is not reset; gating with tx keeps data_o at 0 when empty.
    assign data_o = tx ? mem[rptr] : '0;

    always_ff @(posedge clock) begin
        if (wr) begin
            mem[wptr] <= data_i;
        end
    end

    // Pointers are AW bits wide, so they wrap modulo DEPTH naturally.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr) begin
                wptr <= wptr + AW'(1);
            end
            if (rd) begin
                rptr <= rptr + AW'(1);
            end
            unique case ({wr, rd})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

`ifdef LINK_STATS_EN
    typedef enum logic [1:0] {
        HEADER,
        SIZE,
        PAYLOAD
    } pkt_state_t;

    pkt_state_t            state;
    pkt_state_t            state_n;
    logic [FLIT_WIDTH-1:0] remaining;
    logic [FLIT_WIDTH-1:0] remaining_n;
    logic                  pkt_done;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state      <= HEADER;
            remaining  <= '0;
            flit_cnt_o <= '0;
            pkt_cnt_o  <= '0;
        end else begin
            state     <= state_n;
            remaining <= remaining_n;
            if (rd) begin
                flit_cnt_o <= flit_cnt_o + 32'd1;
            end
            if (pkt_done) begin
                pkt_cnt_o <= pkt_cnt_o + 32'd1;
            end
        end
    end

    // Each delivered flit advances the packet tracker by one step.
    always_comb begin
        state_n     = state;
        remaining_n = remaining;
        pkt_done    = 1'b0;
        if (rd) begin
            unique case (state)
                HEADER: begin
                    state_n = SIZE;
                end
                SIZE: begin
                    remaining_n = data_o;
                    if (data_o == '0) begin
                        state_n  = HEADER;
                        pkt_done = 1'b1;
                    end else begin
                        state_n = PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    remaining_n = remaining - FLIT_WIDTH'(1);
                    if (remaining == FLIT_WIDTH'(1)) begin
                        state_n  = HEADER;
                        pkt_done = 1'b1;
                    end
                end
                default: begin
                    state_n = HEADER;
                end
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_link_buffer.sv
// tb_link_buffer: directed scoreboard bench for link_buffer.
// A reference occupancy/queue model predicts every output each cycle.
module tb_link_buffer;

    localparam int FW = 16;
    localparam int D  = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          rx = 1'b0;
    logic [FW-1:0] data_i = '0;
    logic          credit_i = 1'b0;
    logic          credit_o;
    logic          tx;
    logic [FW-1:0] data_o;
    logic [2:0]    count_o;
`ifdef LINK_STATS_EN
    logic [31:0]   flit_cnt_o;
    logic [31:0]   pkt_cnt_o;
`endif

    link_buffer #(.FLIT_WIDTH(FW), .DEPTH(D)) dut (
        .clock    (clock),
        .reset    (reset),
        .rx       (rx),
        .data_i   (data_i),
        .credit_o (credit_o),
        .tx       (tx),
        .data_o   (data_o),
        .credit_i (credit_i),
        .count_o  (count_o)
`ifdef LINK_STATS_EN
        ,
        .flit_cnt_o (flit_cnt_o),
        .pkt_cnt_o  (pkt_cnt_o)
`endif
    );

    always #5 clock = ~clock;

    int            vectors = 0;
    int            miscompares = 0;
    logic [FW-1:0] sbq [$];
    int            mcount = 0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge: check pre-edge outputs, drive
    // inputs, update the model for the coming rising edge.
    task automatic step(input logic r, input logic [FW-1:0] d,
                        input logic c);
        logic wr;
        logic rd;
        rx       = r;
        data_i   = d;
        credit_i = c;
        chk("count", 32'(count_o), 32'(mcount));
        chk("credit", 32'(credit_o), (mcount < D) ? 32'd1 : 32'd0);
        chk("tx", 32'(tx), (mcount != 0) ? 32'd1 : 32'd0);
        if (mcount != 0) begin
            chk("data", 32'(data_o), 32'(sbq[0]));
        end
        wr = r && (mcount < D);
        rd = c && (mcount > 0);
        if (rd) begin
            void'(sbq.pop_front());
            mcount--;
        end
        if (wr) begin
            sbq.push_back(d);
            mcount++;
        end
        @(negedge clock);
        rx       = 1'b0;
        credit_i = 1'b0;
    endtask

    // Asynchronous reset between clock edges, checked before any edge.
    task automatic do_reset();
        #2;
        reset = 1'b0;
        #1;
        chk("rst_tx", 32'(tx), 32'd0);
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_credit", 32'(credit_o), 32'd1);
        chk("rst_data", 32'(data_o), 32'd0);
`ifdef LINK_STATS_EN
        chk("rst_flit_cnt", flit_cnt_o, 32'd0);
        chk("rst_pkt_cnt", pkt_cnt_o, 32'd0);
`endif
        sbq.delete();
        mcount = 0;
        @(negedge clock);
        reset = 1'b1;
    endtask

    initial begin
        // Power-on reset
        #1;
        chk("por_tx", 32'(tx), 32'd0);
        chk("por_count", 32'(count_o), 32'd0);
        chk("por_credit", 32'(credit_o), 32'd1);
        chk("por_data", 32'(data_o), 32'd0);
        @(negedge clock);
        reset = 1'b1;

        // Fill with downstream stalled
        for (int i = 1; i <= 4; i++) begin
            step(1'b1, FW'(i), 1'b0);
        end
        chk("full_count", 32'(count_o), 32'd4);
        chk("full_credit", 32'(credit_o), 32'd0);
        // Write while full is ignored
        step(1'b1, 16'h0099, 1'b0);
        // Full with simultaneous read: read only
        step(1'b1, 16'h0055, 1'b1);
        chk("full_rd_count", 32'(count_o), 32'd3);
        // Drain remaining flits, then observe empty
        for (int i = 0; i < 4; i++) begin
            step(1'b0, '0, 1'b1);
        end
        chk("drained_tx", 32'(tx), 32'd0);

        // Streaming: count stays 1, pointers wrap several times
        for (int i = 0; i < 20; i++) begin
            step(1'b1, 16'h1000 + FW'(i * 37), 1'b1);
        end
        step(1'b0, '0, 1'b1);
        chk("stream_empty", 32'(count_o), 32'd0);

        // Backpressure: head must hold for 5 stalled cycles
        step(1'b1, 16'hC0DE, 1'b0);
        step(1'b1, 16'hBEEF, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0);
            chk("bp_hold", 32'(data_o), 32'h0000C0DE);
        end
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);

        // Two packets streamed through from a clean reset
        do_reset();
        step(1'b1, 16'h0101, 1'b1);
        step(1'b1, 16'h0002, 1'b1);
        step(1'b1, 16'hAAAA, 1'b1);
        step(1'b1, 16'hBBBB, 1'b1);
        step(1'b1, 16'h0202, 1'b1);
        step(1'b1, 16'h0000, 1'b1);
        step(1'b0, '0, 1'b1);
`ifdef LINK_STATS_EN
        chk("pkt_cnt_2", pkt_cnt_o, 32'd2);
        chk("flit_cnt_6", flit_cnt_o, 32'd6);
`endif

        // Reset mid-packet after 2 of 4 flits read
        do_reset();
        step(1'b1, 16'h0303, 1'b0);
        step(1'b1, 16'h0002, 1'b0);
        step(1'b1, 16'h000A, 1'b0);
        step(1'b1, 16'h000B, 1'b0);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b1);
        do_reset();
        // New packet with size 1; first flit is a header again
        step(1'b1, 16'h0404, 1'b1);
        step(1'b1, 16'h0001, 1'b1);
        step(1'b1, 16'h0C0C, 1'b1);
        step(1'b0, '0, 1'b1);
        step(1'b0, '0, 1'b0);
`ifdef LINK_STATS_EN
        chk("pkt_cnt_1", pkt_cnt_o, 32'd1);
        chk("flit_cnt_3", flit_cnt_o, 32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==",
                 vectors, miscompares);
        $finish;
    end

endmodule
